m68k_bus_ctrl: RTL

M68K_BUS_CTRL -- requirements
Module: m68k_bus_ctrl

---
 rtl/m68k_bus_pkg.sv | 24 ++
 rtl/m68k_addr_match.sv | 29 ++
 rtl/m68k_bus_ctrl.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/m68k_bus_pkg.sv
// Shared definitions for the 68000 bus controller: FSM encoding, default region map, idle bus value.
// Latency: n/a (package).  Backpressure: n/a.
package m68k_bus_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_WAIT    = 3'd1,
        ST_ACK     = 3'd2,
        ST_TIMEOUT = 3'd3,
        ST_BERR    = 3'd4,
        ST_IACK    = 3'd5
    } bus_state_t;

    localparam int DEF_NUM_REGIONS = 4;

    // Region 0 lives in the least significant slice of each packed constant.
    localparam logic [95:0] DEF_REGION_BASE = {24'h600000, 24'h200000, 24'h100000, 24'h000000};
    localparam logic [95:0] DEF_REGION_MASK = {24'hF00000, 24'hFF0000, 24'hFF0000, 24'hFF0000};
    localparam logic [15:0] DEF_REGION_WAIT = {4'd0, 4'd3, 4'd1, 4'd0};

    localparam logic [15:0] IDLE_BUS = 16'hFFFF;
    localparam logic [2:0]  FC_IACK  = 3'b111;

endpackage

// File: rtl/m68k_addr_match.sv
// Purpose: address compare against all regions, lowest matching index wins.
// Latency: combinational.  Backpressure: none, pure decode.
module m68k_addr_match
    import m68k_bus_pkg::*;
#(
    parameter int                          NUM_REGIONS = DEF_NUM_REGIONS,
    parameter logic [NUM_REGIONS*24-1:0]   REGION_BASE = DEF_REGION_BASE,
    parameter logic [NUM_REGIONS*24-1:0]   REGION_MASK = DEF_REGION_MASK,
    parameter int                          IDX_W       = 2
) (
    input  logic [23:1]      addr,
    output logic             hit,
    output logic [IDX_W-1:0] region
);

    // Scan from the top so the lowest matching index is the last one written.
    always_comb begin
        hit    = 1'b0;
        region = '0;
        for (int r = NUM_REGIONS - 1; r >= 0; r--) begin
            if ((addr & REGION_MASK[r*24+1 +: 23]) ==
                (REGION_BASE[r*24+1 +: 23] & REGION_MASK[r*24+1 +: 23])) begin
                hit    = 1'b1;
                region = IDX_W'(r);
            end
        end
    end

endmodule

// File: rtl/m68k_bus_ctrl.sv
// Purpose: 68000 bus cycle controller: region decode, chip selects, wait states, DTACK/BERR/VPA.
// Latency: acknowledge WAIT[r]+1 edges after AS sampled low; BERR after BERR_TIMEOUT edges.
// Backpressure: CPU holds AS low until acknowledged; a new cycle needs AS sampled high first.
module m68k_bus_ctrl
    import m68k_bus_pkg::*;
#(
    parameter int                          NUM_REGIONS  = DEF_NUM_REGIONS,
    parameter logic [NUM_REGIONS*24-1:0]   REGION_BASE  = DEF_REGION_BASE,
    parameter logic [NUM_REGIONS*24-1:0]   REGION_MASK  = DEF_REGION_MASK,
    parameter logic [NUM_REGIONS*4-1:0]    REGION_WAIT  = DEF_REGION_WAIT,
    parameter int                          BERR_TIMEOUT = 64
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      as_n,
    input  logic                      uds_n,
    input  logic                      lds_n,
    input  logic                      rw,
    input  logic [2:0]                fc,
    input  logic [23:1]               addr,
    input  logic [NUM_REGIONS*16-1:0] region_din,
    output logic [15:0]               cpu_din,
    output logic [NUM_REGIONS-1:0]    cs,
    output logic                      dtack_n,
    output logic                      berr_n,
    output logic                      vpa_n
);

    localparam int          IDX_W     = (NUM_REGIONS > 1) ? $clog2(NUM_REGIONS) : 1;
    localparam logic [7:0]  BERR_LOAD = 8'(BERR_TIMEOUT - 2);

    bus_state_t             state_q, state_d;
    logic [7:0]             cnt_q, cnt_d;
    logic [IDX_W-1:0]       region_q, region_d;

    logic                   hit;
    logic [IDX_W-1:0]       hit_idx;
    logic [3:0]             hit_wait;
    logic                   cycle_start;

    logic [NUM_REGIONS-1:0] cs_d;
    logic                   dtack_d, berr_d, vpa_d;

    m68k_addr_match #(
        .NUM_REGIONS (NUM_REGIONS),
        .REGION_BASE (REGION_BASE),
        .REGION_MASK (REGION_MASK),
        .IDX_W       (IDX_W)
    ) u_addr_match (
        .addr   (addr),
        .hit    (hit),
        .region (hit_idx)
    );

    assign hit_wait = REGION_WAIT[int'(hit_idx)*4 +: 4];

    // A write needs at least one data strobe; a read may start on AS alone.
    assign cycle_start = !as_n && (!uds_n || !lds_n || rw);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            region_q <= '0;
            cs       <= '0;
            dtack_n  <= 1'b1;
            berr_n   <= 1'b1;
            vpa_n    <= 1'b1;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            region_q <= region_d;
            cs       <= cs_d;
            dtack_n  <= dtack_d;
            berr_n   <= berr_d;
            vpa_n    <= vpa_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        region_d = region_q;

        unique case (state_q)
            ST_IDLE: begin
                if (cycle_start) begin
                    if (fc == FC_IACK) begin
                        state_d = ST_IACK;
                    end else if (hit) begin
                        region_d = hit_idx;
                        if (hit_wait == 4'd0) begin
                            state_d = ST_ACK;
                        end else begin
                            state_d = ST_WAIT;
                            cnt_d   = {4'b0, hit_wait} - 8'd1;
                        end
                    end else begin
                        state_d = ST_TIMEOUT;
                        cnt_d   = BERR_LOAD;
                    end
                end
            end

            // Releasing AS mid-count abandons the cycle silently.
            ST_WAIT: begin
                if (as_n) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == 8'd0) begin
                    state_d = ST_ACK;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end

            ST_TIMEOUT: begin
                if (as_n) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == 8'd0) begin
                    state_d = ST_BERR;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end

            ST_ACK, ST_BERR, ST_IACK: begin
                if (as_n) begin
                    state_d = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Strobes are registered from the next state so they change on the same edge as the FSM.
    always_comb begin
        cs_d = '0;
        if (state_d == ST_WAIT || state_d == ST_ACK) begin
            cs_d[region_d] = 1'b1;
        end
        dtack_d = (state_d != ST_ACK);
        berr_d  = (state_d != ST_BERR);
        vpa_d   = (state_d != ST_IACK);
    end

    always_comb begin
        cpu_din = IDLE_BUS;
        if (state_q == ST_WAIT || state_q == ST_ACK) begin
            cpu_din = region_din[int'(region_q)*16 +: 16];
        end
    end

endmodule
